// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the FSM top level and the storage array.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W   = 32;
  localparam int unsigned DMEM_MAX_WAIT = 15;
  localparam int unsigned DMEM_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Misaligned or beyond the last word of a DEPTH-word store.
  function automatic logic addr_fault(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || (a >= 32'(depth * 4));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DW storage: one synchronous write port and one registered read port
// sharing a single index. Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = DMEM_DATA_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wdata;
    end
    if (rd_en) begin
      rdata_reg <= mem[idx];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one request, waits WAIT_CYCLES,
// then completes with a one-cycle ready pulse (err on rejected requests).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata,
  output logic                   ready,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [DMEM_CNT_W-1:0] WAIT_LOAD =
    DMEM_CNT_W'((WAIT_CYCLES > DMEM_MAX_WAIT) ? DMEM_MAX_WAIT : WAIT_CYCLES);

  dmem_state_t           state_reg, state_next;
  logic [DMEM_CNT_W-1:0] cnt_reg, cnt_next;

  logic                   write_reg;
  logic                   fault_reg;
  logic [AW-1:0]          idx_reg;
  logic [DMEM_DATA_W-1:0] wdata_reg;

  logic ready_reg;
  logic err_reg;
  logic zero_reg;

  logic                   req;
  logic                   accept;
  logic                   req_fault;
  logic [AW-1:0]          req_idx;
  logic                   enter_resp;
  logic                   acc_write;
  logic                   acc_fault;
  logic [AW-1:0]          acc_idx;
  logic [DMEM_DATA_W-1:0] acc_wdata;
  logic                   mem_wr_en;
  logic                   mem_rd_en;
  logic [DMEM_DATA_W-1:0] mem_rdata;

  assign req       = mem_read | mem_write;
  assign accept    = (state_reg == IDLE) && req;
  assign req_fault = addr_fault(addr, DEPTH) || (mem_read && mem_write);
  assign req_idx   = addr[AW+1:2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (req) begin
          cnt_next   = WAIT_LOAD;
          state_next = (WAIT_LOAD == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == DMEM_CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_next == RESP) && (state_reg != RESP);

  // With zero wait states the access completes straight from IDLE, so the
  // live inputs stand in for the request registers on that edge.
  assign acc_write = (state_reg == IDLE) ? mem_write : write_reg;
  assign acc_fault = (state_reg == IDLE) ? req_fault : fault_reg;
  assign acc_idx   = (state_reg == IDLE) ? req_idx   : idx_reg;
  assign acc_wdata = (state_reg == IDLE) ? wdata     : wdata_reg;

  assign mem_wr_en = rst && enter_resp && !acc_fault && acc_write;
  assign mem_rd_en = rst && enter_resp && !acc_fault && !acc_write;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DMEM_DATA_W)
  ) u_array (
    .clk   (clk),
    .wr_en (mem_wr_en),
    .rd_en (mem_rd_en),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      fault_reg <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      zero_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        write_reg <= mem_write;
        fault_reg <= req_fault;
        idx_reg   <= req_idx;
        wdata_reg <= wdata;
      end
      ready_reg <= enter_resp;
      err_reg   <= enter_resp && acc_fault;
      // zero_reg masks the array read register: set by rejects, cleared by good reads, writes leave it alone
      if (enter_resp) begin
        if (acc_fault) begin
          zero_reg <= 1'b1;
        end else if (!acc_write) begin
          zero_reg <= 1'b0;
        end
      end
    end
  end

  assign rdata = zero_reg ? '0 : mem_rdata;
  assign ready = ready_reg;
  assign err   = err_reg;
  assign busy  = rst && (accept || (state_reg == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Two responders (2 and 0 wait states) share one stimulus stream and are both
// compared every cycle against a cycle-arithmetic reference model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int NW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'h3;
  logic [31:0] wdata = 32'h0;

  logic [31:0] rdata_o [NW];
  logic        ready_o [NW];
  logic        busy_o  [NW];
  logic        err_o   [NW];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_o[0]), .ready(ready_o[0]),
    .busy(busy_o[0]), .err(err_o[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_o[1]), .ready(ready_o[1]),
    .busy(busy_o[1]), .err(err_o[1])
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Reference model: each accepted request is reduced to "completes at cycle
  // accept+W+1 with this effect"; busy is simply "a completion is still ahead".
  int          wc        [NW];
  int          resp_cyc  [NW];
  bit          m_err     [NW];
  bit          m_wr      [NW];
  int          m_idx     [NW];
  logic [31:0] m_data    [NW];
  logic [31:0] exp_rdata [NW];
  logic [31:0] mem_m     [NW][DEPTH];

  initial begin
    bit e_ready, e_err, e_busy;
    wc[0] = 2;
    wc[1] = 0;
    for (int k = 0; k < NW; k++) begin
      resp_cyc[k]  = -1;
      exp_rdata[k] = 32'h0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < NW; k++) begin
        e_ready = 1'b0;
        e_err   = 1'b0;
        if (resp_cyc[k] == cyc) begin
          e_ready = 1'b1;
          e_err   = m_err[k];
          if (m_err[k])     exp_rdata[k] = 32'h0;
          else if (m_wr[k]) mem_m[k][m_idx[k]] = m_data[k];
          else              exp_rdata[k] = mem_m[k][m_idx[k]];
        end
        if (!rst) begin
          e_ready      = 1'b0;
          e_err        = 1'b0;
          exp_rdata[k] = 32'h0;
          resp_cyc[k]  = -1;
        end else if ((mem_read || mem_write) && resp_cyc[k] < cyc) begin
          resp_cyc[k] = cyc + wc[k] + 1;
          m_err[k]    = (addr % 4 != 0) || (addr >= DEPTH * 4) || (mem_read && mem_write);
          m_wr[k]     = mem_write;
          m_idx[k]    = int'((addr / 4) % DEPTH);
          m_data[k]   = wdata;
        end
        e_busy = rst && (cyc < resp_cyc[k]);
        check($sformatf("busy[W=%0d]", wc[k]),  32'(busy_o[k]),  32'(e_busy));
        check($sformatf("ready[W=%0d]", wc[k]), 32'(ready_o[k]), 32'(e_ready));
        check($sformatf("err[W=%0d]", wc[k]),   32'(err_o[k]),   32'(e_err));
        check($sformatf("rdata[W=%0d]", wc[k]), rdata_o[k],      exp_rdata[k]);
      end
      cyc++;
    end
  end

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic rv);
    @(posedge clk);
    #1;
    rst = rv; mem_read = r; mem_write = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, $urandom, $urandom, 1'b1);
  endtask

  // Hold a request through the 2-wait-state busy window; pre presents it one
  // cycle early, i.e. during the previous RESP where it must not be taken.
  task automatic xact(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input bit pre);
    if (!pre) idle(1);
    repeat (3 + int'(pre)) step(r, w, a, d, 1'b1);
  endtask

  // One request from IDLE; returns at the negedge of the W=2 ready cycle.
  task automatic single(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    repeat (3) step(r, w, a, d, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    logic        r, w;
    int          kind;
    bit          pre;

    // Reset held with a read pending
    repeat (2) begin
      step(1'b1, 1'b0, 32'h3, 32'h0, 1'b0);
      check("reset busy", 32'(busy_o[0]), 32'd0);
      check("reset ready", 32'(ready_o[0]), 32'd0);
      check("reset rdata", rdata_o[0], 32'h0);
    end
    step(1'b1, 1'b0, 32'h3, 32'h0, 1'b1);
    check("first accept busy", 32'(busy_o[0]), 32'd1);
    repeat (2) step(1'b1, 1'b0, 32'h3, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("post-reset ready", 32'(ready_o[0]), 32'd1);
    check("post-reset err", 32'(err_o[0]), 32'd1);

    // Give every word a known value
    for (int i = 0; i < int'(DEPTH); i++)
      xact(1'b0, 1'b1, 32'(i) << 2, $urandom, bit'($urandom_range(0, 1)));
    idle(2);

    // Write/read 0x20 with 2 wait states
    for (int t = 0; t < 3; t++) begin
      step(1'b0, 1'b1, 32'h20, 32'hA, 1'b1);
      check("wr20 busy", 32'(busy_o[0]), 32'd1);
      check("wr20 early ready", 32'(ready_o[0]), 32'd0);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("wr20 ready", 32'(ready_o[0]), 32'd1);
    check("wr20 err", 32'(err_o[0]), 32'd0);
    check("wr20 busy in resp", 32'(busy_o[0]), 32'd0);
    single(1'b1, 1'b0, 32'h20, 32'h0);
    check("rd20 rdata", rdata_o[0], 32'hA);

    // Zero wait states, back-to-back
    step(1'b0, 1'b1, 32'h0, 32'h5, 1'b1);
    check("w0 wr busy", 32'(busy_o[1]), 32'd1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    check("w0 wr ready", 32'(ready_o[1]), 32'd1);
    check("w0 no accept in resp", 32'(busy_o[1]), 32'd0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    check("w0 second accept", 32'(busy_o[1]), 32'd1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("w0 rd ready", 32'(ready_o[1]), 32'd1);
    check("w0 rd rdata", rdata_o[1], 32'h5);
    idle(3);

    // Rejected requests
    single(1'b1, 1'b0, 32'h22, 32'h0);
    check("misaligned err", 32'(err_o[0]), 32'd1);
    check("misaligned ready", 32'(ready_o[0]), 32'd1);
    check("misaligned rdata", rdata_o[0], 32'h0);
    single(1'b0, 1'b1, 32'h400, 32'hDEAD);
    check("range err", 32'(err_o[0]), 32'd1);
    single(1'b1, 1'b0, 32'h0, 32'h0);
    check("loc0 intact", rdata_o[0], 32'h5);
    single(1'b1, 1'b1, 32'h8, 32'h99);
    check("rd+wr err", 32'(err_o[0]), 32'd1);

    // Reset during the wait states of a write
    single(1'b0, 1'b1, 32'h10, 32'h77);
    step(1'b0, 1'b1, 32'h10, 32'hFF, 1'b1);
    step(1'b0, 1'b0, 32'h10, 32'hFF, 1'b0);
    for (int t = 0; t < 4; t++) begin
      check("aborted no ready", 32'(ready_o[0]), 32'd0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
    single(1'b1, 1'b0, 32'h10, 32'h0);
    check("aborted write", rdata_o[0], 32'h77);

    // rdata holds across a write completion
    single(1'b0, 1'b1, 32'h30, 32'h1234);
    single(1'b1, 1'b0, 32'h30, 32'h0);
    check("rd30 rdata", rdata_o[0], 32'h1234);
    single(1'b0, 1'b1, 32'h34, 32'hBEEF);
    check("hold ready", 32'(ready_o[0]), 32'd1);
    check("hold rdata", rdata_o[0], 32'h1234);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 99));
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (kind < 5)       a = a | 32'($urandom_range(1, 3));
      else if (kind < 8)  a = 32'h400 + (32'($urandom_range(0, 1023)) << 2);
      else if (kind < 10) a = $urandom | 32'h8000_0000;
      kind = int'($urandom_range(0, 19));
      r = (kind < 10) || (kind == 19);
      w = (kind >= 10);
      pre = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 29) == 0) begin
        idle(1);
        repeat ($urandom_range(1, 3)) step(r, w, a, $urandom, 1'b1);
        step(1'b0, 1'b0, $urandom, $urandom, 1'b0);
        idle(3);
      end else begin
        xact(r, w, a, $urandom, pre);
      end
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
